// File: rtl/mmind_pkg.sv
// Shared constants, FSM encoding and peg helper for the Mastermind scorer.
// A code is NUM_PEGS pegs of PEG_W bits each; peg i sits at [PEG_W*i +: PEG_W].
package mmind_pkg;
  localparam int NUM_PEGS   = 4;
  localparam int PEG_W      = 2;
  localparam int NUM_COLORS = 4;
  localparam int CNT_W      = 3;
  localparam int CODE_W     = NUM_PEGS * PEG_W;
  localparam int IDX_W      = 2;  // walks both pegs (EXACT) and colours (COLOR)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXACT = 2'd1,
    ST_COLOR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [PEG_W-1:0] peg_get(input logic [CODE_W-1:0] code,
                                               input logic [IDX_W-1:0]  idx);
    return code[idx*PEG_W +: PEG_W];
  endfunction
endpackage

// File: rtl/mmind_color_count.sv
// Combinational count of unmasked pegs of a given colour.
//   code_i  : packed code (secret or guess)
//   mask_i  : pegs already consumed by exact matches (1 = skip)
//   color_i : colour to count
//   count_o : number of unmasked pegs equal to color_i (0..4)
module mmind_color_count
  import mmind_pkg::*;
(
  input  logic [CODE_W-1:0]   code_i,
  input  logic [NUM_PEGS-1:0] mask_i,
  input  logic [PEG_W-1:0]    color_i,
  output logic [CNT_W-1:0]    count_o
);
  always_comb begin
    count_o = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (!mask_i[p] && (peg_get(code_i, IDX_W'(p)) == color_i))
        count_o = count_o + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mmind_scorer.sv
// Sequential Mastermind scorer. On start, latches secret/guess, walks the pegs
// for exact matches (masking them), then walks the colours adding
// min(secret count, guess count) over unmasked pegs as white pegs.
//   clk_i, rst_ni       : clock, async active-low reset
//   start_i             : score request, only honoured in IDLE
//   secret_i, guess_i   : packed codes, sampled on the accepting edge
//   busy_o              : high whenever not IDLE
//   done_o              : one-cycle pulse, results valid while high
//   black_o, white_o    : exact / colour-only counts
//   win_o               : black_o == 4
module mmind_scorer
  import mmind_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [CODE_W-1:0] secret_i,
  input  logic [CODE_W-1:0] guess_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  black_o,
  output logic [CNT_W-1:0]  white_o,
  output logic              win_o
);
  state_e                state_q, state_d;
  logic [CODE_W-1:0]     sec_q, sec_d, gss_q, gss_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_PEGS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]      blk_q, blk_d, wht_q, wht_d;
  logic [CNT_W-1:0]      black_q, black_d, white_q, white_d;
  logic                  win_q, win_d;
  logic [CNT_W-1:0]      n_sec, n_gss, n_min;

  // In COLOR the index doubles as the colour being counted.
  mmind_color_count u_cnt_sec (.code_i(sec_q), .mask_i(mask_q), .color_i(idx_q), .count_o(n_sec));
  mmind_color_count u_cnt_gss (.code_i(gss_q), .mask_i(mask_q), .color_i(idx_q), .count_o(n_gss));

  assign n_min = (n_sec < n_gss) ? n_sec : n_gss;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    gss_d   = gss_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    blk_d   = blk_q;
    wht_d   = wht_q;
    black_d = black_q;
    white_d = white_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_EXACT;
          sec_d   = secret_i;
          gss_d   = guess_i;
          idx_d   = '0;
          mask_d  = '0;
          blk_d   = '0;
          wht_d   = '0;
        end
      end
      ST_EXACT: begin
        if (peg_get(sec_q, idx_q) == peg_get(gss_q, idx_q)) begin
          blk_d         = blk_q + CNT_W'(1);
          mask_d[idx_q] = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);  // wraps to 0, ready for colour 0
        if (idx_q == IDX_W'(NUM_PEGS-1)) state_d = ST_COLOR;
      end
      ST_COLOR: begin
        wht_d = wht_q + n_min;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_COLORS-1)) begin
          // Load results on the edge entering DONE so they are valid with done.
          state_d = ST_DONE;
          black_d = blk_q;
          white_d = wht_d;
          win_d   = (blk_q == CNT_W'(NUM_PEGS));
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      gss_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      blk_q   <= '0;
      wht_q   <= '0;
      black_q <= '0;
      white_q <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      gss_q   <= gss_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      blk_q   <= blk_d;
      wht_q   <= wht_d;
      black_q <= black_d;
      white_q <= white_d;
      win_q   <= win_d;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign black_o = black_q;
  assign white_o = white_q;
  assign win_o   = win_q;
endmodule

// File: tb/tb_mmind_scorer.sv
module tb_mmind_scorer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] secret = '0, guess = '0;
  logic       busy, done, win;
  logic [2:0] black, white;
  int checks = 0, errors = 0;

  mmind_scorer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .secret_i(secret), .guess_i(guess),
    .busy_o(busy), .done_o(done), .black_o(black), .white_o(white), .win_o(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: black = positional matches; total = sum over colours of
  // min(colour count in secret, colour count in guess); white = total - black.
  function automatic void model(input logic [7:0] s, input logic [7:0] g,
                                output int b, output int w);
    int cs[4], cg[4], tot;
    logic [1:0] ps, pg;
    b = 0; tot = 0;
    for (int c = 0; c < 4; c++) begin cs[c] = 0; cg[c] = 0; end
    for (int p = 0; p < 4; p++) begin
      ps = s[2*p +: 2]; pg = g[2*p +: 2];
      if (ps == pg) b++;
      cs[ps]++; cg[pg]++;
    end
    for (int c = 0; c < 4; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    w = tot - b;
  endfunction

  task automatic run_score(input logic [7:0] s, input logic [7:0] g, input int eb,
                           input int ew, input bit disturb, input string tag);
    int busyc = 0, donec = 0, doneat = -1, ob = -1, ow = -1, owin = -1;
    bit fin = 0;
    @(negedge clk);
    secret = s; guess = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin secret = 8'($urandom); guess = 8'($urandom); end
    for (int n = 0; n < 30 && !fin; n++) begin
      if (busy) busyc++;
      if (done) begin donec++; doneat = busyc; ob = black; ow = white; owin = win; end
      start = (disturb && n == 2);
      if (!busy) fin = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_ndone"}, donec, 1);
    chk({tag, "_busy"}, busyc, 9);
    chk({tag, "_doneat"}, doneat, 9);
    chk({tag, "_black"}, ob, eb);
    chk({tag, "_white"}, ow, ew);
    chk({tag, "_win"}, owin, int'(eb == 4));
    @(negedge clk);
    chk({tag, "_hold"}, int'(black), eb);
  endtask

  task automatic run_rand(input string tag, input bit disturb);
    logic [7:0] s, g;
    int b, w;
    s = 8'($urandom);
    g = ($urandom_range(0, 3) == 0) ? s : 8'($urandom);
    model(s, g, b, w);
    run_score(s, g, b, w, disturb, tag);
  endtask

  initial begin
    int dc;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_black", int'(black), 0);
    chk("rst_white", int'(white), 0);
    chk("rst_win", int'(win), 0);
    @(negedge clk); rst_n = 1'b1;

    run_score(8'hE4, 8'hE4, 4, 0, 1'b0, "same");
    run_score(8'hE4, 8'h4E, 0, 4, 1'b0, "swap");
    run_score(8'hE4, 8'h94, 2, 1, 1'b0, "mix");
    run_score(8'h00, 8'h05, 2, 0, 1'b0, "dup");
    run_score(8'hE4, 8'hE4, 4, 0, 1'b1, "ignore");

    // Reset mid-COLOR: outputs cleared at once, no done afterwards.
    @(negedge clk);
    secret = 8'hE4; guess = 8'h4E; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_black", int'(black), 0);
    chk("midrst_white", int'(white), 0);
    chk("midrst_win", int'(win), 0);
    @(negedge clk); rst_n = 1'b1;
    dc = 0;
    for (int n = 0; n < 12; n++) begin
      if (done || busy) dc++;
      @(negedge clk);
    end
    chk("midrst_quiet", dc, 0);
    run_score(8'hE4, 8'h94, 2, 1, 1'b0, "postrst");

    for (int i = 0; i < 40; i++) run_rand($sformatf("rnd%0d", i), i[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
